ex_mem_reg: RTL
===============

// Module: ex_mem_reg
// PURPOSE
//   EX->MEM pipeline register: captures EX-stage results each cycle and feeds the
//   MEM stage (wdata/wd/wreg, whilo/hi/lo). Implements stall and flush so the
//   pipeline freezes or bubbles correctly. Carries the two-cycle multiply-
//   accumulate state (hilo_temp, cnt) back to EX while EX is stalled.
// PARAMETERS
//   REG_W   32  data width of GPR/HI/LO values
//   ADDR_W  5   GPR address width
//   CNT_W   2   multi-cycle step counter width
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         asynchronous reset, active-high
//   stall        in   6         pipeline stall vector; [3]=EX stalled, [4]=MEM stalled
//   flush        in   1         synchronous flush (exception/redirect), kills this slot
//   ex_wdata     in   REG_W     EX result to write back
//   ex_wd        in   ADDR_W    destination GPR
//   ex_wreg      in   1         GPR write enable
//   ex_whilo     in   1         HI/LO write enable
//   ex_hi        in   REG_W     HI value
//   ex_lo        in   REG_W     LO value
//   hilo_i       in   2*REG_W   EX partial accumulate value to preserve
//   cnt_i        in   CNT_W     EX multi-cycle step count to preserve
//   mem_wdata    out  REG_W     registered to MEM stage
//   mem_wd       out  ADDR_W    registered to MEM stage
//   mem_wreg     out  1         registered to MEM stage
//   mem_whilo    out  1         registered to MEM stage
//   mem_hi       out  REG_W     registered to MEM stage
//   mem_lo       out  REG_W     registered to MEM stage
//   hilo_o       out  2*REG_W   preserved accumulate value, back to EX
//   cnt_o        out  CNT_W     preserved step count, back to EX
// BEHAVIOUR
//   - All outputs are flops; latency EX->MEM = 1 cycle. No combinational paths.
//   - rst=1 (async, immediate): every output = 0 (mem_wd=NOP addr 0, mem_wreg=0,
//     mem_whilo=0, hilo_o=0, cnt_o=0). Reset mid-operation discards any in-flight
//     accumulate state.
//   - Priority at each rising edge (rst low): flush > bubble > hold > advance.
//   - FLUSH (flush=1): all outputs <= 0, regardless of stall.
//   - BUBBLE (stall[3]=1, stall[4]=0): EX stalled, MEM runs -> insert NOP:
//     mem_* <= 0 (wreg=0, whilo=0); hilo_o <= hilo_i; cnt_o <= cnt_i.
//   - HOLD (stall[3]=1, stall[4]=1): all outputs keep previous value.
//   - ADVANCE (stall[3]=0): mem_* <= ex_*; hilo_o <= 0; cnt_o <= 0
//     (instruction left EX, accumulate state retired).
//   - stall[3]=0 with stall[4]=1 is illegal (stall vector is monotone); treat as
//     ADVANCE; bench flags it with an assertion.
//   - Other stall bits ignored. No width conversion; values pass bit-exact.
//   - Effective state: conceptually VALID/BUBBLE/HELD; no explicit FSM register
//     beyond the output flops.
// TESTING
//   1. rst pulse mid-cycle with outputs nonzero -> all outputs 0 before next edge.
//   2. stall=0, ex_wd=5, ex_wreg=1, ex_wdata=32'hDEADBEEF -> next edge mem_wd=5,
//      mem_wreg=1, mem_wdata=DEADBEEF; cnt_o=0.
//   3. stall=6'b001111, hilo_i=64'h1_0000_0002, cnt_i=1, ex_wreg=1 -> mem_wreg=0,
//      mem_whilo=0, hilo_o=64'h1_0000_0002, cnt_o=1; then stall=0, ex_whilo=1,
//      ex_hi=1, ex_lo=3 -> mem_whilo=1, mem_hi=1, mem_lo=3, cnt_o=0, hilo_o=0.
//   4. valid slot latched, then stall=6'b011111 for 3 cycles with ex_* changing ->
//      all outputs unchanged for 3 cycles.
//   5. flush=1 with stall=6'b011111 and valid slot held -> next edge all outputs 0.
//   6. stall=6'b010111 (illegal) -> behaves as ADVANCE; assertion fires.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush handling.
// Also carries multi-cycle accumulate state back to EX while EX is stalled.
module ex_mem_reg #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               flush,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic               ex_whilo,
  input  logic [REG_W-1:0]   ex_hi,
  input  logic [REG_W-1:0]   ex_lo,
  input  logic [2*REG_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [REG_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic               mem_whilo,
  output logic [REG_W-1:0]   mem_hi,
  output logic [REG_W-1:0]   mem_lo,
  output logic [2*REG_W-1:0] hilo_o,
  output logic [CNT_W-1:0]   cnt_o
);

  logic bubble;
  logic hold;
  logic unused_stall;

  // EX stalled while MEM runs -> NOP into MEM; both stalled -> freeze.
  // stall[3]=0 with stall[4]=1 falls through to advance.
  assign bubble       = stall[3] & ~stall[4];
  assign hold         = stall[3] & stall[4];
  assign unused_stall = ^{stall[5], stall[2:0]};

  // MEM-side slot: flush > bubble > hold > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wdata <= '0;
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
    end else if (flush || bubble) begin
      mem_wdata <= '0;
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
    end else if (!hold) begin
      mem_wdata <= ex_wdata;
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_whilo <= ex_whilo;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
    end
  end

  // Accumulate state: kept only while EX is stalled, retired on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end else if (flush) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end else if (bubble) begin
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else if (!hold) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end
  end

endmodule
